// File: rtl/matdet_gauss.sv
// Fixed-point determinant by Gaussian elimination with partial pivoting.
// A single FSM walks a working copy of the matrix: one pivot candidate, one column, or one divide bit per cycle.
module matdet_gauss #(
    parameter int DATA_WIDTH  = 16,
    parameter int BIN_POS     = 8,
    parameter int MATRIX_SIZE = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] matrix,
    output logic                                          ready,
    output logic                                          complete,
    output logic [DATA_WIDTH-1:0]                         det,
    output logic                                          singular,
    output logic                                          overflow
);
    localparam int W  = DATA_WIDTH;
    localparam int F  = BIN_POS;
    localparam int N  = MATRIX_SIZE;
    localparam int QW = W + F;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(QW) + 1;
    localparam logic [IW-1:0] LAST     = IW'(N - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(QW - 1);
    localparam logic [W-1:0]  ONE      = W'(64'd1 << F);
    localparam logic [QW-1:0] POS_LIM  = QW'((64'd1 << (W - 1)) - 64'd1);
    localparam logic [QW-1:0] NEG_LIM  = QW'(64'd1 << (W - 1));

    typedef enum logic [2:0] {IDLE, LOAD, SEARCH, SWAP, DIV, ELIM, ACC, DONE} state_t;

    state_t                       state_q;
    logic [N-1:0][N-1:0][W-1:0]   a_q;
    logic [IW-1:0]                k_q, r_q, s_q, c_q, piv_q;
    logic [W-1:0]                 max_q;
    logic [CW-1:0]                cnt_q;
    logic [W-1:0]                 rem_q, dvs_q;
    logic [QW-1:0]                quo_q;
    logic                         neg_q;
    logic [W-1:0]                 factor_q, det_acc_q;
    logic                         sign_q, ov_q;
    logic                         ready_q, complete_q, singular_q;
    logic [W-1:0]                 det_q;

    // Magnitude of a signed value as unsigned; the most negative value maps to 2^(W-1).
    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return x[W-1] ? (~x + 1'b1) : x;
    endfunction

    // Returns {overflow, wrapped result} of (a*b) >>> F.
    function automatic logic [W:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] p;
        logic signed [2*W-1:0] s;
        p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        s = p >>> F;
        return {~((&s[2*W-1:W-1]) | ~(|s[2*W-1:W-1])), s[W-1:0]};
    endfunction

    logic [W-1:0]  srch_mag, cur_max;
    logic [IW-1:0] cur_piv;
    logic          srch_take;
    logic [W:0]    acc_mul, elim_mul;
    logic [W-1:0]  elim_d, det_fin;
    logic [IW-1:0] div_row;
    logic [W-1:0]  dvd_mag, dvs_mag;
    logic          dvd_neg;
    logic [W:0]    rem_sh;
    logic          div_ge, div_ov;
    logic [W-1:0]  rem_d, factor_d;
    logic [QW-1:0] quo_d;

    always_comb begin
        srch_mag  = mag(a_q[s_q][k_q]);
        srch_take = (s_q == k_q) || (srch_mag > max_q);
        cur_max   = srch_take ? srch_mag : max_q;
        cur_piv   = srch_take ? s_q : piv_q;

        acc_mul  = fmul(det_acc_q, a_q[k_q][k_q]);
        det_fin  = sign_q ? (~acc_mul[W-1:0] + 1'b1) : acc_mul[W-1:0];
        elim_mul = fmul(factor_q, a_q[k_q][c_q]);
        elim_d   = a_q[r_q][c_q] - elim_mul[W-1:0];

        // Row whose divide is set up next: first row below the pivot from ACC, else the following row.
        div_row = (state_q == ACC) ? k_q + 1'b1 : r_q + 1'b1;
        dvd_mag = mag(a_q[div_row][k_q]);
        dvs_mag = mag(a_q[k_q][k_q]);
        dvd_neg = a_q[div_row][k_q][W-1] ^ a_q[k_q][k_q][W-1];

        rem_sh   = {rem_q, quo_q[QW-1]};
        div_ge   = rem_sh >= {1'b0, dvs_q};
        rem_d    = div_ge ? W'(rem_sh - {1'b0, dvs_q}) : rem_sh[W-1:0];
        quo_d    = {quo_q[QW-2:0], div_ge};
        div_ov   = neg_q ? (quo_d > NEG_LIM) : (quo_d > POS_LIM);
        factor_d = neg_q ? (~quo_d[W-1:0] + 1'b1) : quo_d[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            complete_q <= 1'b0;
            det_q      <= '0;
            singular_q <= 1'b0;
            ov_q       <= 1'b0;
            k_q        <= '0;
            r_q        <= '0;
            s_q        <= '0;
            c_q        <= '0;
            piv_q      <= '0;
            max_q      <= '0;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            neg_q      <= 1'b0;
            factor_q   <= '0;
            det_acc_q  <= '0;
            sign_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q        <= matrix;
                        det_acc_q  <= ONE;
                        sign_q     <= 1'b0;
                        ov_q       <= 1'b0;
                        complete_q <= 1'b0;
                        ready_q    <= 1'b0;
                        singular_q <= 1'b0;
                        det_q      <= '0;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    k_q     <= '0;
                    s_q     <= '0;
                    state_q <= SEARCH;
                end
                SEARCH: begin
                    max_q <= cur_max;
                    piv_q <= cur_piv;
                    if (s_q == LAST) begin
                        if (cur_max == '0) begin
                            singular_q <= 1'b1;
                            det_q      <= '0;
                            complete_q <= 1'b1;
                            ready_q    <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            state_q <= SWAP;
                        end
                    end else begin
                        s_q <= s_q + 1'b1;
                    end
                end
                SWAP: begin
                    if (piv_q != k_q) begin
                        a_q[k_q]   <= a_q[piv_q];
                        a_q[piv_q] <= a_q[k_q];
                        sign_q     <= ~sign_q;
                    end
                    state_q <= ACC;
                end
                ACC: begin
                    det_acc_q <= acc_mul[W-1:0];
                    ov_q      <= ov_q | acc_mul[W];
                    if (k_q == LAST) begin
                        det_q      <= det_fin;
                        singular_q <= 1'b0;
                        complete_q <= 1'b1;
                        ready_q    <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        r_q     <= k_q + 1'b1;
                        cnt_q   <= '0;
                        rem_q   <= '0;
                        quo_q   <= {dvd_mag, {F{1'b0}}};
                        dvs_q   <= dvs_mag;
                        neg_q   <= dvd_neg;
                        state_q <= DIV;
                    end
                end
                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == DIV_LAST) begin
                        factor_q <= factor_d;
                        ov_q     <= ov_q | div_ov;
                        c_q      <= k_q + 1'b1;
                        state_q  <= ELIM;
                    end
                end
                ELIM: begin
                    a_q[r_q][c_q] <= elim_d;
                    ov_q          <= ov_q | elim_mul[W];
                    if (c_q == LAST) begin
                        if (r_q == LAST) begin
                            k_q     <= k_q + 1'b1;
                            s_q     <= k_q + 1'b1;
                            state_q <= SEARCH;
                        end else begin
                            r_q     <= r_q + 1'b1;
                            cnt_q   <= '0;
                            rem_q   <= '0;
                            quo_q   <= {dvd_mag, {F{1'b0}}};
                            dvs_q   <= dvs_mag;
                            neg_q   <= dvd_neg;
                            state_q <= DIV;
                        end
                    end else begin
                        c_q <= c_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready    = ready_q;
    assign complete = complete_q;
    assign det      = det_q;
    assign singular = singular_q;
    assign overflow = ov_q;
endmodule

// File: doc/matdet_gauss.md
MATDET_GAUSS -- requirements
Module: matdet_gauss

Interface
REQ-001 Parameter DATA_WIDTH, default 16, signed two's-complement fixed-point element and result width.
REQ-002 Parameter BIN_POS, default 8, fractional bit count (0 < BIN_POS < DATA_WIDTH).
REQ-003 Parameter MATRIX_SIZE, default 4, matrix dimension N (N >= 2).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  request; accepted only when ready=1.
REQ-007 matrix  in  N*N*DATA_WIDTH  element (row i, col j) at bits [(i*N+j)*DATA_WIDTH +: DATA_WIDTH]; sampled on accepted start only.
REQ-008 ready  out  1  high in IDLE and DONE (able to accept start).
REQ-009 complete  out  1  high in DONE only; results valid while high.
REQ-010 det  out  DATA_WIDTH  determinant, same fixed-point format as elements.
REQ-011 singular  out  1  zero pivot found; det forced to 0.
REQ-012 overflow  out  1  sticky for current job; any product or quotient exceeded signed DATA_WIDTH range.

Function
REQ-013 Algorithm: Gaussian elimination with partial pivoting on an internal N*N working copy; det = (+/-1) * product of pivots.
REQ-014 States: IDLE, LOAD, SEARCH, SWAP, DIV, ELIM, ACC, DONE.
REQ-015 IDLE/DONE + start: LOAD (1 cycle, copy matrix, det_acc=1.0, sign=+, overflow=0, complete=0, k=0).
REQ-016 SEARCH: examine rows k..N-1 of column k, one row per cycle (N-k cycles); pivot = largest magnitude; ties -> lowest row index.
REQ-017 SEARCH end with max magnitude 0: go to DONE, det=0, singular=1.
REQ-018 SWAP: 1 cycle always; if pivot row != k exchange rows and flip sign, else no change.
REQ-019 ACC: 1 cycle; det_acc <= fmul(det_acc, a[k][k]); if k=N-1 go to DONE, else r=k+1 and go to DIV.
REQ-020 DIV: factor = (a[r][k] <<< BIN_POS) / a[k][k]; sequential restoring divide on magnitudes, exactly DATA_WIDTH+BIN_POS cycles; sign applied after; truncation toward zero.
REQ-021 ELIM: columns j=k+1..N-1, one per cycle (N-k-1 cycles): a[r][j] <= a[r][j] - fmul(factor, a[k][j]); column k of row r not needed after.
REQ-022 After ELIM: r<N-1 -> r+1, DIV; r=N-1 -> k+1, SEARCH.
REQ-023 fmul(a,b) = (a*b) >>> BIN_POS on full 2*DATA_WIDTH product (arithmetic shift, floor); keep low DATA_WIDTH bits (wrap).
REQ-024 Subtraction, negation and final sign wrap modulo 2^DATA_WIDTH.
REQ-025 overflow set if any fmul or DIV result, before truncation, lies outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; wrapped result still used.
REQ-026 Entering DONE (non-singular): det = sign ? -det_acc : det_acc, singular=0.
REQ-027 DONE: complete=1, ready=1, det/singular/overflow held until accepted start or rst.
REQ-028 start while not ready ignored; matrix changes while busy have no effect.
REQ-029 Latency (start edge to complete=1) = 1 + sum over k of [(N-k) + 2 + (N-k-1)*(DATA_WIDTH+BIN_POS + N-k-1)], less skipped columns on singular exit.

Reset
REQ-030 rst=1 at a clock edge: next state IDLE; ready=1, complete=0, det=0, singular=0, overflow=0; overrides start.
REQ-031 rst asserted mid-job aborts it; no partial result is ever presented with complete=1.
REQ-032 Working matrix contents unspecified after reset; not observable.

Verification (DATA_WIDTH=16, BIN_POS=8)
REQ-033 N=3 identity (diag 0x0100) -> det=0x0100, singular=0, overflow=0; complete at latency per REQ-029.
REQ-034 N=2 [[0,1.0],[1.0,0]] -> one swap; det=0xFF00 (-1.0), singular=0.
REQ-035 N=2 [[1.0,2.0],[3.0,4.0]] -> pivot 3.0, factor 0x0055, a[1][1]=0x00AC, det=0xFDFC (truncation error vs -2.0 is exact required value).
REQ-036 N=3 with rows 0 and 2 identical -> singular=1, det=0x0000, complete=1.
REQ-037 N=2 diag [100.0,100.0] (0x6400) -> overflow=1, det=0x1000.
REQ-038 rst pulsed during DIV, then start with identity -> complete stays 0 during abort; new job yields det=0x0100 at full latency.
